pwm_sample_scheduler: RTL and testbench



---
 rtl/sdr_pwm_pkg.sv | 21 ++
 rtl/sdr_sample_fifo.sv | 57 +++++
 rtl/pwm_sample_scheduler.sv | 139 +++++++++++++
 tb/tb_pwm_sample_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pwm_pkg.sv
// Shared types and constants for the PWM sample scheduler.
package sdr_pwm_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 1024;
  localparam int FRAME_W   = $clog2(FRAME_LEN);

  typedef logic [DATA_W-1:0]  sample_t;
  typedef logic [FRAME_W-1:0] frame_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    UNDERRUN,
    MUTE
  } state_t;

  localparam sample_t MUTE_SAMPLE = '0;

endpackage

// File: rtl/sdr_sample_fifo.sv
// Small synchronous sample FIFO; flush wins over push/pop, push is honoured
// when full only if a pop happens in the same cycle.
module sdr_sample_fifo
  import sdr_pwm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  sample_t       push_data,
  input  logic          pop,
  output sample_t       pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  sample_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Feeds the PWM DAC one sample per frame from a two-source arbitrated FIFO.
// Define PWM_SCHED_STATS_EN to build the saturating underrun counter.
//
// state    | meaning
// IDLE     | disabled, muted, FIFO flushed
// FILL     | collecting samples from owner until FILL_LEVEL at a strobe
// RUN      | playing, one pop per frame strobe
// UNDERRUN | FIFO ran dry, holding last sample, counting empty strobes
// MUTE     | one-cycle flush before re-arbitration
module pwm_sample_scheduler
  import sdr_pwm_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FILL_LEVEL  = 2,
  parameter int UNDER_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  output logic [DATA_W-1:0] pwm_data,
  output logic              frame_strobe,
  output logic              owner,
  output logic              muted,
  output logic [15:0]       underrun_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = $clog2(UNDER_LIMIT + 1);

  state_t     state, state_nxt;
  frame_cnt_t frame_cnt;
  logic       pop, push, flush, full, empty, accepting, empty_tick;
  logic [CW-1:0] count;
  logic [UW-1:0] under;
  sample_t    head;

  assign frame_strobe = (frame_cnt == frame_cnt_t'(FRAME_LEN - 1));
  assign push = (src0_valid && src0_ready) || (src1_valid && src1_ready);

  sdr_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (owner ? src1_data : src0_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = FILL;
        FILL:
          if (frame_strobe && count >= CW'(FILL_LEVEL)) begin
            state_nxt = RUN;
            pop       = 1'b1;
          end
        RUN:
          if (frame_strobe) begin
            if (empty) state_nxt = UNDERRUN;
            else       pop       = 1'b1;
          end
        UNDERRUN:
          if (frame_strobe) begin
            if (!empty) begin
              state_nxt = RUN;
              pop       = 1'b1;
            end else if (under + UW'(1) == UW'(UNDER_LIMIT)) begin
              state_nxt = MUTE;
            end
          end
        MUTE: state_nxt = FILL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    accepting  = (state == FILL) || (state == RUN) || (state == UNDERRUN);
    src0_ready = accepting && !owner && !full;
    src1_ready = accepting && owner && !full;
    muted      = !((state == RUN) || (state == UNDERRUN));
    flush      = !enable || (state == IDLE) || (state == MUTE);
    empty_tick = enable && frame_strobe && empty &&
                 ((state == RUN) || (state == UNDERRUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      owner     <= 1'b0;
      pwm_data  <= MUTE_SAMPLE;
      under     <= '0;
    end else begin
      frame_cnt <= frame_cnt + frame_cnt_t'(1);
      // Owner is latched only when leaving IDLE or MUTE; otherwise locked.
      if (enable && (state == IDLE || state == MUTE)) begin
        if (src0_valid)      owner <= 1'b0;
        else if (src1_valid) owner <= 1'b1;
      end
      if (!enable || state == IDLE)             pwm_data <= MUTE_SAMPLE;
      else if (pop)                             pwm_data <= head;
      else if (state_nxt == MUTE && state != MUTE) pwm_data <= MUTE_SAMPLE;
      if (!enable || state == IDLE || state == MUTE || pop) under <= '0;
      else if (empty_tick)                                   under <= under + UW'(1);
    end
  end

`ifdef PWM_SCHED_STATS_EN
  logic [15:0] underrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 underrun_q <= '0;
    else if (empty_tick && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
  end
  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Scoreboard bench for pwm_sample_scheduler: accepted samples are queued and
// compared against pwm_data at frame strobes.
module tb_pwm_sample_scheduler;

`ifdef PWM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [11:0] src0_data, src1_data;
  logic        src0_valid, src1_valid, src0_ready, src1_ready;
  logic [11:0] pwm_data;
  logic        frame_strobe, owner, muted;
  logic [15:0] underrun_cnt;

  int          checks = 0;
  int          errors = 0;
  int          stab_viol = 0;
  int          rdy_viol = 0;
  logic [11:0] sb [$];
  logic [11:0] exp;
  logic        e_q, s_q;
  logic [11:0] p_q;

  pwm_sample_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .src0_data    (src0_data),
    .src0_valid   (src0_valid),
    .src0_ready   (src0_ready),
    .src1_data    (src1_data),
    .src1_valid   (src1_valid),
    .src1_ready   (src1_ready),
    .pwm_data     (pwm_data),
    .frame_strobe (frame_strobe),
    .owner        (owner),
    .muted        (muted),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard producer: record every handshake on the rising edge.
  always @(posedge clk) begin
    if (src0_valid && src0_ready) sb.push_back(src0_data);
    if (src1_valid && src1_ready) sb.push_back(src1_data);
    e_q <= enable;
    s_q <= frame_strobe;
    p_q <= pwm_data;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && e_q === 1'b1 && s_q === 1'b0 && pwm_data !== p_q) stab_viol++;
    if ((owner === 1'b0 && src1_ready === 1'b1) || (owner === 1'b1 && src0_ready === 1'b1)) rdy_viol++;
  end

  task automatic to_strobe_edge();
    int n = 0;
    while (frame_strobe !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: waited %0d cycles, required < 3000", n);
    end
    @(negedge clk);
  endtask

  task automatic send0(input logic [11:0] v);
    int n = 0;
    src0_data = v; src0_valid = 1'b1;
    while (src0_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL src0_ready_timeout: value %0d not accepted", v);
    end
    @(negedge clk);
    src0_valid = 1'b0;
  endtask

  task automatic send1(input logic [11:0] v);
    int n = 0;
    src1_data = v; src1_valid = 1'b1;
    while (src1_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL src1_ready_timeout: value %0d not accepted", v);
    end
    @(negedge clk);
    src1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0; src0_data = '0; src1_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_data !== 12'd0) begin errors++; $display("FAIL reset_pwm: got %h want 000", pwm_data); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", frame_strobe); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner); end
    checks++; if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted: got %b want 1", muted); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt); end
    checks++; if ({src0_ready, src1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {src0_ready, src1_ready}); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL reset_fifo: got %0d want 0", dut.u_fifo.count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_run();
    src1_data = 12'd7; src1_valid = 1'b1;
    enable = 1'b1;
    send0(12'd100);
    send0(12'd200);
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL fill_owner: got %b want 0", owner); end
    checks++; if (muted !== 1'b1 || pwm_data !== 12'd0) begin errors++; $display("FAIL fill_muted: got muted=%b pwm=%h want 1/000", muted, pwm_data); end
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL fill_count: got %0d want 2", dut.u_fifo.count); end
    for (int i = 0; i < 2; i++) begin
      to_strobe_edge();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL run_sb_empty: strobe %0d", i); end
      else begin
        exp = sb.pop_front();
        checks++; if (pwm_data !== exp) begin errors++; $display("FAIL run_pwm: got %0d want %0d", pwm_data, exp); end
      end
      checks++; if (muted !== 1'b0) begin errors++; $display("FAIL run_muted: got %b want 0", muted); end
    end
  endtask

  task automatic test_underrun_mute();
    src1_data = 12'hE00;
    for (int i = 1; i <= 3; i++) begin
      to_strobe_edge();
      exp = (i < 3) ? 12'd200 : 12'd0;
      checks++; if (pwm_data !== exp) begin errors++; $display("FAIL under_pwm%0d: got %0d want %0d", i, pwm_data, exp); end
      checks++; if (muted !== (i == 3)) begin errors++; $display("FAIL under_muted%0d: got %b want %b", i, muted, (i == 3)); end
      checks++; if (underrun_cnt !== (STATS ? 16'(i) : 16'd0)) begin errors++; $display("FAIL under_cnt%0d: got %0d want %0d", i, underrun_cnt, (STATS ? i : 0)); end
    end
    sb.delete();
  endtask

  task automatic test_src1_owner();
    src0_valid = 1'b0;
    send1(12'hE00);
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL s1_owner: got %b want 1", owner); end
    send1(12'hE01);
    checks++; if (muted !== 1'b1 || pwm_data !== 12'd0) begin errors++; $display("FAIL s1_fill: got muted=%b pwm=%h want 1/000", muted, pwm_data); end
    for (int i = 0; i < 2; i++) begin
      to_strobe_edge();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL s1_sb_empty: strobe %0d", i); end
      else begin
        exp = sb.pop_front();
        checks++; if (pwm_data !== exp) begin errors++; $display("FAIL s1_pwm: got %h want %h", pwm_data, exp); end
      end
    end
  endtask

  task automatic test_enable_drop();
    send1(12'd30); send1(12'd31); send1(12'd32);
    to_strobe_edge();
    exp = sb.size() ? sb.pop_front() : 12'hFFF;
    checks++; if (pwm_data !== exp) begin errors++; $display("FAIL drop_pre_pwm: got %0d want %0d", pwm_data, exp); end
    repeat (500) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (pwm_data !== 12'd0) begin errors++; $display("FAIL drop_pwm: got %0d want 0", pwm_data); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL drop_fifo: got %0d want 0", dut.u_fifo.count); end
    checks++; if ({src0_ready, src1_ready} !== 2'b00 || muted !== 1'b1) begin errors++; $display("FAIL drop_ready: got rdy=%b muted=%b want 00/1", {src0_ready, src1_ready}, muted); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    for (int v = 1; v <= 4; v++) send0(12'(v));
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d want 4", dut.u_fifo.count); end
    src0_data = 12'd5; src0_valid = 1'b1;
    checks++; if (src0_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", src0_ready); end
    to_strobe_edge();
    exp = sb.size() ? sb.pop_front() : 12'hFFF;
    checks++; if (pwm_data !== exp) begin errors++; $display("FAIL b2b_first: got %0d want %0d", pwm_data, exp); end
    @(negedge clk);
    src0_valid = 1'b0;
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL b2b_refill: got %0d want 4", dut.u_fifo.count); end
    for (int i = 2; i <= 5; i++) begin
      to_strobe_edge();
      exp = sb.size() ? sb.pop_front() : 12'hFFF;
      checks++; if (pwm_data !== exp || pwm_data !== 12'(i)) begin errors++; $display("FAIL b2b_order: got %0d want %0d", pwm_data, i); end
    end
    checks++; if (sb.size() != 0 || dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got sb=%0d fifo=%0d want 0/0", sb.size(), dut.u_fifo.count); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_monitors();
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL pwm_stable: got %0d mid-frame changes want 0", stab_viol); end
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL nonowner_ready: got %0d cycles want 0", rdy_viol); end
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_underrun_mute();
    test_src1_owner();
    test_enable_drop();
    test_back_to_back();
    test_monitors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
